// File: rtl/sd_seq_check.sv
// sd_seq_check: srdy/drdy consumer that applies a drdy pattern and checks a +1 data sequence
// Ports:
//   clk, reset               rising-edge clock, asynchronous active-high reset
//   c_srdy, c_data, c_drdy   upstream handshake; c_drdy is registered
//   drdy_pat                 backpressure pattern, bit i = ready in slot i
//   expected                 next expected word
//   ok_cnt, err_cnt          saturating match / mismatch counters
//   err, err_exp, err_got    sticky first-error flag and captured values
module sd_seq_check #(
  parameter int width   = 8,
  parameter int pat_dep = 8,
  parameter int cnt_w   = 16,
  parameter int startup = 10
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               c_srdy,
  output logic               c_drdy,
  input  logic [width-1:0]   c_data,
  input  logic [pat_dep-1:0] drdy_pat,
  output logic [width-1:0]   expected,
  output logic [cnt_w-1:0]   ok_cnt,
  output logic [cnt_w-1:0]   err_cnt,
  output logic               err,
  output logic [width-1:0]   err_exp,
  output logic [width-1:0]   err_got
);
  localparam int PW = pat_dep > 1 ? $clog2(pat_dep) : 1;
  typedef enum logic [1:0] {ST_STARTUP, ST_SYNC, ST_CHECK} state_t;
  state_t           r_state, w_next;
  logic [7:0]       r_scnt;
  logic [PW-1:0]    r_ppos;
  logic             r_drdy, r_err;
  logic [width-1:0] r_exp, r_err_exp, r_err_got;
  logic [cnt_w-1:0] r_ok, r_errc;
  logic             w_xfer, w_run, w_good, w_done;
  assign w_xfer = c_srdy & r_drdy;
  assign w_done = r_scnt == 8'(startup);
  // the pattern starts on the same edge STARTUP ends, so slot 0 appears startup+1 edges after release
  assign w_run  = r_state != ST_STARTUP || w_done;
  // the first word seen in SYNC is taken as the sequence seed
  assign w_good = r_state == ST_SYNC || c_data == r_exp;
  always_comb begin
    w_next = r_state;
    if (r_state == ST_STARTUP && w_done) w_next = ST_SYNC;
    else if (r_state == ST_SYNC && w_xfer) w_next = ST_CHECK;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) r_state <= ST_STARTUP;
    else r_state <= w_next;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_scnt    <= '0;
      r_ppos    <= '0;
      r_drdy    <= 1'b0;
      r_exp     <= '0;
      r_ok      <= '0;
      r_errc    <= '0;
      r_err     <= 1'b0;
      r_err_exp <= '0;
      r_err_got <= '0;
    end else begin
      if (r_state == ST_STARTUP && !w_done) r_scnt <= r_scnt + 8'd1;
      if (w_run) begin
        r_drdy <= drdy_pat[r_ppos];
        r_ppos <= r_ppos == PW'(pat_dep - 1) ? '0 : r_ppos + PW'(1);
      end
      if (w_xfer && r_state != ST_STARTUP) begin
        // match or mismatch, the stream resynchronises to the word just received
        r_exp <= c_data + width'(1);
        if (w_good) r_ok <= r_ok + cnt_w'(r_ok != '1);
        else begin
          r_errc <= r_errc + cnt_w'(r_errc != '1);
          if (!r_err) begin
            r_err     <= 1'b1;
            r_err_exp <= r_exp;
            r_err_got <= c_data;
          end
        end
      end
    end
  end
  assign c_drdy   = r_drdy;
  assign expected = r_exp;
  assign ok_cnt   = r_ok;
  assign err_cnt  = r_errc;
  assign err      = r_err;
  assign err_exp  = r_err_exp;
  assign err_got  = r_err_got;
endmodule

// File: tb/tb_sd_seq_check.sv
// tb_sd_seq_check: directed self-checking bench for sd_seq_check
module tb_sd_seq_check;
  logic        clk = 0, reset = 1, c_srdy = 0, c_drdy, err;
  logic [7:0]  c_data = 0, drdy_pat = 8'hFF, expected, err_exp, err_got;
  logic [15:0] ok_cnt, err_cnt;
  int          n_vec = 0, n_bad = 0, hi;
  int unsigned wq[$];
  logic [7:0]  pat_exp;

  sd_seq_check dut (
    .clk(clk), .reset(reset), .c_srdy(c_srdy), .c_drdy(c_drdy), .c_data(c_data),
    .drdy_pat(drdy_pat), .expected(expected), .ok_cnt(ok_cnt), .err_cnt(err_cnt),
    .err(err), .err_exp(err_exp), .err_got(err_got)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_vec++;
    assert (got === want) else begin
      n_bad++;
      $error("FAIL %s observed %0h expected %0h", tag, got, want);
    end
  endtask

  task automatic do_reset();
    reset = 1;
    repeat (2) @(posedge clk);
    #1 reset = 0;
  endtask

  task automatic send();
    int i = 0, guard = 0;
    logic x;
    while (i < wq.size() && guard < 5000) begin
      c_srdy = 1;
      c_data = 8'(wq[i]);
      @(negedge clk);
      x = c_drdy;
      @(posedge clk);
      #1;
      if (x) i++;
      guard++;
    end
    c_srdy = 0;
    chk("send_timeout", 64'(guard < 5000), 64'd1);
    wq.delete();
    @(negedge clk);
  endtask

  initial begin
    do_reset();
    @(negedge clk);
    chk("reset_state", {c_drdy, expected, ok_cnt, err_cnt, err, err_exp, err_got}, 64'd0);
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); #1;
      chk($sformatf("startup_low_%0d", k), 64'(c_drdy), 64'd0);
    end
    @(posedge clk); #1;
    chk("first_drdy", 64'(c_drdy), 64'd1);

    for (int v = 1; v <= 300; v++) wq.push_back(v);
    send();
    chk("ff_ok", ok_cnt, 64'd300);
    chk("ff_errcnt", err_cnt, 64'd0);
    chk("ff_err", err, 64'd0);
    chk("ff_expected", expected, 64'h2D);

    drdy_pat = 8'hA5;
    do_reset();
    repeat (10) @(posedge clk);
    pat_exp = 8'b10100101;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      chk($sformatf("a5_slot%0d", k), 64'(c_drdy), 64'(pat_exp[k]));
    end
    for (int v = 10; v < 60; v++) wq.push_back(v);
    send();
    chk("a5_ok", ok_cnt, 64'd50);
    chk("a5_errcnt", err_cnt, 64'd0);

    drdy_pat = 8'hFF;
    do_reset();
    wq = '{1, 2, 3, 7, 8, 9};
    send();
    chk("one_fault_errcnt", err_cnt, 64'd1);
    chk("one_fault_err", err, 64'd1);
    chk("one_fault_exp", err_exp, 64'd4);
    chk("one_fault_got", err_got, 64'd7);
    chk("one_fault_ok", ok_cnt, 64'd5);

    do_reset();
    wq = '{1, 2, 9, 10, 20, 21};
    send();
    chk("two_fault_errcnt", err_cnt, 64'd2);
    chk("two_fault_exp", err_exp, 64'd3);
    chk("two_fault_got", err_got, 64'd9);
    chk("two_fault_ok", ok_cnt, 64'd4);
    chk("two_fault_expected", expected, 64'd22);

    drdy_pat = 8'h00;
    do_reset();
    c_srdy = 1;
    c_data = 8'd5;
    hi = 0;
    repeat (100) begin
      @(negedge clk);
      if (c_drdy) hi++;
    end
    chk("zero_pat_drdy", 64'(hi), 64'd0);
    chk("zero_pat_ok", ok_cnt, 64'd0);
    drdy_pat = 8'hFF;
    wq = '{42, 43, 44, 45, 46};
    send();
    chk("resume_ok", ok_cnt, 64'd5);
    chk("resume_errcnt", err_cnt, 64'd0);

    do_reset();
    for (int v = 1; v <= 20; v++) wq.push_back(v == 10 ? 99 : v);
    send();
    chk("pre_reset_err", err, 64'd1);
    chk("pre_reset_ok", ok_cnt, 64'd18);
    #2 reset = 1;
    #1;
    chk("async_reset", {c_drdy, expected, ok_cnt, err_cnt, err, err_exp, err_got}, 64'd0);
    @(posedge clk);
    #1 reset = 0;
    hi = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (c_drdy) hi++;
    end
    chk("rerun_startup_low", 64'(hi), 64'd0);
    wq = '{200, 201, 202, 203, 204};
    send();
    chk("rerun_ok", ok_cnt, 64'd5);
    chk("rerun_errcnt", err_cnt, 64'd0);
    chk("rerun_err", err, 64'd0);
    chk("rerun_expected", expected, 64'd205);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
